// File: rtl/rx_ber_pkg.sv
// Shared types and helpers for the rx symbol error checker.
// Provides chk_state_t, the default counter width and sat_inc().
package rx_ber_pkg;

    localparam int CNT_W_DEF = 32;
    localparam int MAX_W     = 64;

    typedef enum logic [1:0] {
        ALIGN  = 2'd0,
        LOCKED = 2'd1,
        LOST   = 2'd2
    } chk_state_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [MAX_W-1:0] sat_inc(
        input logic [MAX_W-1:0] v,
        input int               w
    );
        logic [MAX_W-1:0] lim;
        lim = {MAX_W{1'b1}} >> (MAX_W - w);
        return (v >= lim) ? lim : v + MAX_W'(1);
    endfunction

endpackage

// File: rtl/rx_symbol_error_checker_if.sv
// Handshake/bus bundle of the rx symbol error checker.
// master drives ref/rx/clear and reads status; slave is the checker.
interface rx_symbol_error_checker_if #(
    parameter int SR    = 8,
    parameter int CNT_W = 32
);
    logic [SR-1:0]    ref_symbol;
    logic             ref_valid;
    logic [SR-1:0]    rx_symbol;
    logic             rx_valid;
    logic             clear;
    logic             locked;
    logic             lock_lost;
    logic [CNT_W-1:0] symbol_count;
    logic [CNT_W-1:0] error_count;
    logic [15:0]      slip_count;
    logic             ref_overflow;
    logic             ref_underflow;
    logic [CNT_W-1:0] first_err_idx;
    logic [SR-1:0]    first_err_ref;
    logic [SR-1:0]    first_err_rx;

    modport master (
        output ref_symbol, ref_valid, rx_symbol, rx_valid, clear,
        input  locked, lock_lost, symbol_count, error_count,
        input  slip_count, ref_overflow, ref_underflow,
        input  first_err_idx, first_err_ref, first_err_rx
    );

    modport slave (
        input  ref_symbol, ref_valid, rx_symbol, rx_valid, clear,
        output locked, lock_lost, symbol_count, error_count,
        output slip_count, ref_overflow, ref_underflow,
        output first_err_idx, first_err_ref, first_err_rx
    );
endinterface

// File: rtl/ref_symbol_fifo.sv
// Reference symbol FIFO: one push, 0/1/2 pops per cycle.
// Ports: clk, rstn, push, din, pop_n, head, full, empty, count.
module ref_symbol_fifo #(
    parameter  int W     = 8,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic [1:0]   pop_n,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          wr_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign wr_en = push && (!full || (pop_n != 2'd0));
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_ptr + AW'(pop_n);
            count  <= count + (AW+1)'(wr_en) - (AW+1)'(pop_n);
        end
    end
endmodule

// File: rtl/rx_symbol_error_checker.sv
// Compares DFE decided symbols against buffered Tx reference symbols:
// slips to align, locks, counts errors, detects loss of lock.
// Ports: clk, rstn, bus (slave: ref/rx strobes, clear, status counters).
// Optional ERR_CAPTURE_EN: latch index/ref/rx of the first locked error.
module rx_symbol_error_checker
    import rx_ber_pkg::*;
#(
    parameter int SIGNAL_RESOLUTION = 8,
    parameter int REF_FIFO_DEPTH    = 64,
    parameter int ALIGN_RUN         = 16,
    parameter int WINDOW_LEN        = 256,
    parameter int LOSS_THRESH       = 32,
    parameter int CNT_W             = CNT_W_DEF
) (
    input logic                      clk,
    input logic                      rstn,
    rx_symbol_error_checker_if.slave bus
);
    localparam int SR    = SIGNAL_RESOLUTION;
    localparam int AW    = $clog2(REF_FIFO_DEPTH);
    localparam int RUN_W = $clog2(ALIGN_RUN + 1);
    localparam int WC_W  = $clog2(WINDOW_LEN + 1);
    localparam int WE_W  = $clog2(LOSS_THRESH + 1);

    chk_state_t       state;
    logic [RUN_W-1:0] run;
    logic [WC_W-1:0]  win_cnt;
    logic [WE_W-1:0]  win_err;
    logic             locked_q;
    logic             lost_q;
    logic [CNT_W-1:0] sym_q;
    logic [CNT_W-1:0] err_q;
    logic [15:0]      slip_q;
    logic             ovf_q;
    logic             unf_q;

    logic [SR-1:0]    head;
    logic             full;
    logic             empty;
    logic [AW:0]      fcnt;
    logic             cmp;
    logic             match;
    logic             slip;
    logic [1:0]       pop_n;
    logic [WC_W-1:0]  win_cnt_nx;
    logic [WE_W-1:0]  win_err_nx;

    ref_symbol_fifo #(
        .W     (SR),
        .DEPTH (REF_FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (bus.ref_valid),
        .din   (bus.ref_symbol),
        .pop_n (pop_n),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (fcnt)
    );

    assign cmp   = bus.rx_valid && !empty;
    assign match = cmp && (bus.rx_symbol == head);
    assign slip  = (state == ALIGN) && cmp && !match;

    // A slip drops head and next so the reference gains one entry on rx.
    always_comb begin
        pop_n = 2'd0;
        if (slip && (fcnt >= (AW+1)'(2))) pop_n = 2'd2;
        else if (cmp)                     pop_n = 2'd1;
    end

    assign win_cnt_nx = win_cnt + WC_W'(1);
    assign win_err_nx = win_err + WE_W'(!match);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ALIGN;
            run      <= '0;
            win_cnt  <= '0;
            win_err  <= '0;
            locked_q <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            lost_q <= 1'b0;
            unique case (state)
                ALIGN: begin
                    if (cmp && match) begin
                        if (run == RUN_W'(ALIGN_RUN - 1)) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                            run      <= '0;
                        end else begin
                            run <= run + RUN_W'(1);
                        end
                    end else if (cmp) begin
                        run <= '0;
                    end
                end
                LOCKED: begin
                    if (cmp) begin
                        if (win_err_nx == WE_W'(LOSS_THRESH)) begin
                            state    <= LOST;
                            locked_q <= 1'b0;
                            lost_q   <= 1'b1;
                        end else if (win_cnt_nx == WC_W'(WINDOW_LEN)) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_cnt_nx;
                            win_err <= win_err_nx;
                        end
                    end
                end
                LOST: begin
                    state   <= ALIGN;
                    win_cnt <= '0;
                    win_err <= '0;
                end
                default: state <= ALIGN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sym_q  <= '0;
            err_q  <= '0;
            slip_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else if (bus.clear) begin
            sym_q  <= '0;
            err_q  <= '0;
            slip_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            if (bus.ref_valid && full && (pop_n == 2'd0)) ovf_q <= 1'b1;
            if (bus.rx_valid && empty) unf_q <= 1'b1;
            if (slip) slip_q <= 16'(sat_inc(MAX_W'(slip_q), 16));
            if ((state == LOCKED) && cmp) begin
                sym_q <= CNT_W'(sat_inc(MAX_W'(sym_q), CNT_W));
                if (!match) err_q <= CNT_W'(sat_inc(MAX_W'(err_q), CNT_W));
            end
        end
    end

`ifdef ERR_CAPTURE_EN
    logic             armed;
    logic [CNT_W-1:0] cap_idx;
    logic [SR-1:0]    cap_ref;
    logic [SR-1:0]    cap_rx;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            armed   <= 1'b1;
            cap_idx <= '0;
            cap_ref <= '0;
            cap_rx  <= '0;
        end else if (bus.clear) begin
            armed   <= 1'b1;
            cap_idx <= '0;
            cap_ref <= '0;
            cap_rx  <= '0;
        end else if (armed && (state == LOCKED) && cmp && !match) begin
            armed   <= 1'b0;
            cap_idx <= sym_q;
            cap_ref <= head;
            cap_rx  <= bus.rx_symbol;
        end
    end

    assign bus.first_err_idx = cap_idx;
    assign bus.first_err_ref = cap_ref;
    assign bus.first_err_rx  = cap_rx;
`else
    assign bus.first_err_idx = '0;
    assign bus.first_err_ref = '0;
    assign bus.first_err_rx  = '0;
`endif

    assign bus.locked        = locked_q;
    assign bus.lock_lost     = lost_q;
    assign bus.symbol_count  = sym_q;
    assign bus.error_count   = err_q;
    assign bus.slip_count    = slip_q;
    assign bus.ref_overflow  = ovf_q;
    assign bus.ref_underflow = unf_q;
endmodule

// File: tb/tb_rx_symbol_error_checker.sv
// Self-checking bench for rx_symbol_error_checker: vector table,
// directed corner sequences and randomized traffic vs a queue model.
module tb_rx_symbol_error_checker;
    localparam int SR    = 8;
    localparam int DEPTH = 64;
    localparam int CW    = 32;
    localparam longint unsigned CMAX = 64'hFFFF_FFFF;

    logic clk;
    logic rstn;

    rx_symbol_error_checker_if #(.SR(SR), .CNT_W(CW)) bus ();

    rx_symbol_error_checker #(
        .SIGNAL_RESOLUTION (SR),
        .REF_FIFO_DEPTH    (DEPTH),
        .ALIGN_RUN         (16),
        .WINDOW_LEN        (256),
        .LOSS_THRESH       (32),
        .CNT_W             (CW)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass;
    int n_total;

    // Behavioural model: reference queue plus mode/run/window bookkeeping.
    bit [7:0]          mq[$];
    int                m_mode;
    int                m_run;
    int                m_wcnt;
    int                m_werr;
    longint unsigned   m_sym;
    longint unsigned   m_err;
    longint unsigned   m_slip;
    bit                m_ovf;
    bit                m_unf;
    bit                m_lost;
    bit                m_armed;
    longint unsigned   m_fidx;
    bit [7:0]          m_fref;
    bit [7:0]          m_frx;

    bit [7:0] prbs[4096];
    bit [7:0] src[8192];
    int       rp;
    int       xp;
    int       n_ll;

    typedef struct {
        bit       rv;
        bit [7:0] rs;
        bit       xv;
        bit [7:0] xs;
        bit       clr;
        bit       e_lock;
        int       e_slip;
        bit       e_unf;
        bit       e_ovf;
    } vec_t;

    vec_t tbl[8];

    function automatic void chk(string nm, longint unsigned act,
                                longint unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_mode  = 0;
        m_run   = 0;
        m_wcnt  = 0;
        m_werr  = 0;
        m_sym   = 0;
        m_err   = 0;
        m_slip  = 0;
        m_ovf   = 0;
        m_unf   = 0;
        m_lost  = 0;
        m_armed = 1;
        m_fidx  = 0;
        m_fref  = 0;
        m_frx   = 0;
    endfunction

    function automatic void model_step(bit rv, bit [7:0] rs, bit xv,
                                       bit [7:0] xs, bit clr);
        int       pops;
        bit       cmp;
        bit       hit;
        bit       ovf_ev;
        bit       unf_ev;
        bit       slip_ev;
        bit       sym_ev;
        bit       err_ev;
        bit [7:0] h;
        pops    = 0;
        hit     = 0;
        h       = 0;
        slip_ev = 0;
        sym_ev  = 0;
        err_ev  = 0;
        ovf_ev  = 0;
        cmp     = xv && (mq.size() > 0);
        unf_ev  = xv && (mq.size() == 0);
        if (cmp) begin
            h   = mq[0];
            hit = (h == xs);
        end
        m_lost = 0;
        case (m_mode)
            0: if (cmp) begin
                pops = (!hit && mq.size() >= 2) ? 2 : 1;
                if (hit) begin
                    m_run++;
                    if (m_run == 16) begin
                        m_mode = 1;
                        m_run  = 0;
                    end
                end else begin
                    m_run   = 0;
                    slip_ev = 1;
                end
            end
            1: if (cmp) begin
                pops   = 1;
                sym_ev = 1;
                err_ev = !hit;
                m_wcnt++;
                if (!hit) m_werr++;
                if (m_werr == 32) begin
                    m_mode = 2;
                    m_lost = 1;
                end else if (m_wcnt == 256) begin
                    m_wcnt = 0;
                    m_werr = 0;
                end
            end
            default: begin
                if (cmp) pops = 1;
                m_mode = 0;
                m_wcnt = 0;
                m_werr = 0;
            end
        endcase
        for (int k = 0; k < pops; k++) void'(mq.pop_front());
        if (rv) begin
            if (mq.size() < DEPTH) mq.push_back(rs);
            else ovf_ev = 1;
        end
        if (clr) begin
            m_sym   = 0;
            m_err   = 0;
            m_slip  = 0;
            m_ovf   = 0;
            m_unf   = 0;
            m_armed = 1;
            m_fidx  = 0;
            m_fref  = 0;
            m_frx   = 0;
        end else begin
            if (ovf_ev) m_ovf = 1;
            if (unf_ev) m_unf = 1;
            if (slip_ev && m_slip < 65535) m_slip++;
`ifdef ERR_CAPTURE_EN
            if (err_ev && m_armed) begin
                m_armed = 0;
                m_fidx  = m_sym;
                m_fref  = h;
                m_frx   = xs;
            end
`endif
            if (sym_ev && m_sym < CMAX) m_sym++;
            if (err_ev && m_err < CMAX) m_err++;
        end
    endfunction

    function automatic void check_all(string t);
        chk({t, ".locked"}, bus.locked, m_mode == 1);
        chk({t, ".lock_lost"}, bus.lock_lost, m_lost);
        chk({t, ".symbol_count"}, bus.symbol_count, m_sym);
        chk({t, ".error_count"}, bus.error_count, m_err);
        chk({t, ".slip_count"}, bus.slip_count, m_slip);
        chk({t, ".ref_overflow"}, bus.ref_overflow, m_ovf);
        chk({t, ".ref_underflow"}, bus.ref_underflow, m_unf);
        chk({t, ".first_err_idx"}, bus.first_err_idx, m_fidx);
        chk({t, ".first_err_ref"}, bus.first_err_ref, m_fref);
        chk({t, ".first_err_rx"}, bus.first_err_rx, m_frx);
    endfunction

    task automatic cycle(string t, bit rv, bit [7:0] rs, bit xv,
                         bit [7:0] xs, bit clr);
        bus.ref_valid  = rv;
        bus.ref_symbol = rs;
        bus.rx_valid   = xv;
        bus.rx_symbol  = xs;
        bus.clear      = clr;
        model_step(rv, rs, xv, xs, clr);
        @(posedge clk);
        #1;
        check_all(t);
        bus.ref_valid = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.clear     = 1'b0;
    endtask

    task automatic do_reset(string t);
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        #1;
        check_all(t);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        bit [7:0] s;
        bit [7:0] x;
        bit       rv;
        bit       xv;
        bit       clr;
        int       ph;
        int       er;
        n_pass  = 0;
        n_total = 0;
        rstn    = 1'b0;
        bus.ref_valid  = 1'b0;
        bus.ref_symbol = '0;
        bus.rx_valid   = 1'b0;
        bus.rx_symbol  = '0;
        bus.clear      = 1'b0;
        model_reset();

        s = 8'h01;
        for (int i = 0; i < 4096; i++) begin
            prbs[i] = s;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
        for (int i = 0; i < 8192; i++) src[i] = 8'($urandom);

        // Vector table: underflow, single-entry slip, push during empty rx.
        tbl[0] = '{0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0};
        tbl[1] = '{0, 8'h00, 1, 8'h22, 0, 0, 0, 1, 0};
        tbl[2] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0};
        tbl[3] = '{1, 8'h11, 0, 8'h00, 0, 0, 0, 0, 0};
        tbl[4] = '{0, 8'h00, 1, 8'h22, 0, 0, 1, 0, 0};
        tbl[5] = '{1, 8'h33, 1, 8'h44, 0, 0, 1, 1, 0};
        tbl[6] = '{0, 8'h00, 1, 8'h33, 0, 0, 1, 1, 0};
        tbl[7] = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0};

        do_reset("rst0");
        for (int i = 0; i < 8; i++) begin
            cycle("tbl", tbl[i].rv, tbl[i].rs, tbl[i].xv,
                  tbl[i].xs, tbl[i].clr);
            chk($sformatf("tbl%0d.locked", i), bus.locked, tbl[i].e_lock);
            chk($sformatf("tbl%0d.slip", i), bus.slip_count, tbl[i].e_slip);
            chk($sformatf("tbl%0d.unf", i), bus.ref_underflow, tbl[i].e_unf);
            chk($sformatf("tbl%0d.ovf", i), bus.ref_overflow, tbl[i].e_ovf);
        end

        // 1: reference leads by 3 garbage entries.
        do_reset("t1rst");
        for (int i = 0; i < 3; i++) cycle("t1", 1, 8'h00, 0, 8'h00, 0);
        for (int i = 0; i < 30; i++) cycle("t1", 1, prbs[i], 0, 8'h00, 0);
        rp = 30;
        for (int i = 0; i < 19; i++) begin
            cycle("t1", 0, 8'h00, 1, prbs[i], 0);
            if (i == 2) chk("t1_slips3", bus.slip_count, 3);
            if (i == 17) chk("t1_not_locked", bus.locked, 0);
        end
        xp = 19;
        chk("t1_locked", bus.locked, 1);
        chk("t1_slips", bus.slip_count, 3);
        chk("t1_errs", bus.error_count, 0);

        // 2: 5 corrupted of 1000 while locked.
        for (int i = 0; i < 1000; i++) begin
            x = prbs[xp];
            if (i == 10 || i == 200 || i == 255 || i == 256 || i == 999)
                x = x ^ 8'h5A;
            cycle("t2", 1, prbs[rp], 1, x, 0);
            rp++;
            xp++;
        end
        chk("t2_syms", bus.symbol_count, 1000);
        chk("t2_errs", bus.error_count, 5);
        chk("t2_locked", bus.locked, 1);

        // 3: 32 consecutive errors lose lock, then relock.
        do_reset("t3rst");
        for (int i = 0; i < 20; i++) cycle("t3", 1, prbs[i], 0, 8'h00, 0);
        rp = 20;
        xp = 0;
        for (int i = 0; i < 16; i++) begin
            cycle("t3", 1, prbs[rp], 1, prbs[xp], 0);
            rp++;
            xp++;
        end
        chk("t3_locked0", bus.locked, 1);
        n_ll = 0;
        for (int i = 0; i < 32; i++) begin
            cycle("t3", 1, prbs[rp], 1, ~prbs[xp], 0);
            n_ll += int'(bus.lock_lost);
            rp++;
            xp++;
        end
        chk("t3_lost_pulse", bus.lock_lost, 1);
        chk("t3_unlocked", bus.locked, 0);
        chk("t3_errs", bus.error_count, 32);
        cycle("t3", 1, prbs[rp], 0, 8'h00, 0);
        rp++;
        n_ll += int'(bus.lock_lost);
        chk("t3_pulse_once", n_ll, 1);
        for (int i = 0; i < 16; i++) begin
            cycle("t3", 1, prbs[rp], 1, prbs[xp], 0);
            n_ll += int'(bus.lock_lost);
            if (i == 14) chk("t3_relock_early", bus.locked, 0);
            rp++;
            xp++;
        end
        chk("t3_relocked", bus.locked, 1);
        chk("t3_pulse_total", n_ll, 1);

        // 4: overflow then drain 64 held entries, then underflow.
        do_reset("t4rst");
        for (int i = 0; i < 70; i++) begin
            cycle("t4", 1, prbs[100+i], 0, 8'h00, 0);
            if (i == 63) chk("t4_no_ovf", bus.ref_overflow, 0);
        end
        chk("t4_ovf", bus.ref_overflow, 1);
        for (int i = 0; i < 64; i++) cycle("t4", 0, 8'h00, 1, prbs[100+i], 0);
        chk("t4_locked", bus.locked, 1);
        chk("t4_syms", bus.symbol_count, 48);
        chk("t4_errs", bus.error_count, 0);
        chk("t4_no_unf", bus.ref_underflow, 0);
        cycle("t4", 0, 8'h00, 1, 8'h00, 0);
        chk("t4_unf", bus.ref_underflow, 1);

        // 5: clear beats a same-cycle error; next error is captured.
        do_reset("t5rst");
        for (int i = 0; i < 8; i++) cycle("t5", 1, prbs[i], 0, 8'h00, 0);
        rp = 8;
        xp = 0;
        for (int i = 0; i < 19; i++) begin
            cycle("t5", 1, prbs[rp], 1, prbs[xp], 0);
            rp++;
            xp++;
        end
        chk("t5_syms3", bus.symbol_count, 3);
        cycle("t5", 1, prbs[rp], 1, prbs[xp] ^ 8'hFF, 1);
        rp++;
        xp++;
        chk("t5_clr_syms", bus.symbol_count, 0);
        chk("t5_clr_errs", bus.error_count, 0);
        chk("t5_clr_locked", bus.locked, 1);
        cycle("t5", 1, prbs[rp], 1, prbs[xp] ^ 8'hFF, 0);
        chk("t5_errs", bus.error_count, 1);
`ifdef ERR_CAPTURE_EN
        chk("t5_cap_idx", bus.first_err_idx, 0);
        chk("t5_cap_ref", bus.first_err_ref, prbs[xp]);
        chk("t5_cap_rx", bus.first_err_rx, prbs[xp] ^ 8'hFF);
`else
        chk("t5_cap_idx", bus.first_err_idx, 0);
        chk("t5_cap_rx", bus.first_err_rx, 0);
`endif
        rp++;
        xp++;

        // 6: async reset mid-lock with the FIFO about half full.
        do_reset("t6rst");
        for (int i = 0; i < 48; i++) cycle("t6", 1, prbs[i], 0, 8'h00, 0);
        for (int i = 0; i < 19; i++) cycle("t6", 0, 8'h00, 1, prbs[i], 0);
        chk("t6_locked", bus.locked, 1);
        chk("t6_syms", bus.symbol_count, 3);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_locked", bus.locked, 0);
        chk("t6_rst_syms", bus.symbol_count, 0);
        check_all("t6async");
        @(negedge clk);
        rstn = 1'b1;
        cycle("t6", 0, 8'h00, 1, prbs[19], 0);
        chk("t6_empty_unf", bus.ref_underflow, 1);
        chk("t6_align", bus.locked, 0);

        // Randomized traffic with error bursts and FIFO pressure.
        do_reset("rnd_rst");
        for (int i = 0; i < 3; i++) cycle("rnd", 1, 8'($urandom), 0, 8'h00, 0);
        rp = 0;
        xp = 0;
        for (int i = 0; i < 4000; i++) begin
            ph  = (i / 500) % 4;
            er  = (ph == 0) ? 0 : (ph == 1) ? 1 : (ph == 2) ? 60 : 2;
            rv  = ($urandom_range(99) < ((ph == 3) ? 80 : 55));
            xv  = ($urandom_range(99) < ((ph == 3) ? 30 : 50));
            clr = ($urandom_range(499) == 0);
            x   = src[xp % 8192];
            if ($urandom_range(99) < er) x = x + 8'd1;
            cycle("rnd", rv, src[rp % 8192], xv, x, clr);
            if (rv) rp++;
            if (xv) xp++;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
